// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: ALU opcodes, writeback-select codes, datapath width.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

endpackage

// File: rtl/ex_mem_stage_alu.sv
// Combinational RV32 ALU: eight operations plus a zero-result flag.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         op,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic [4:0] w_shamt;
    logic       w_lt;

    assign w_shamt = b[4:0];
    assign w_lt    = ($signed(a) < $signed(b));

    // Operation select
    always_comb begin
        result = {XLEN{1'b0}};
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << w_shamt;
            ALU_SRL: result = a >> w_shamt;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, w_lt};
            default: result = {XLEN{1'b0}};
        endcase
    end

    assign zero = (result == {XLEN{1'b0}});

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register with stall, flush and an
// instruction counter for everything that reaches the memory stage.
module ex_mem_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             stall,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [XLEN-1:0]  alu_input1,
    input  logic [XLEN-1:0]  alu_input2,
    input  logic [2:0]       alu_control,
    input  logic [XLEN-1:0]  data_memory_store_in,
    input  logic             reg_write_in,
    input  logic [4:0]       rd_address_in,
    input  logic             data_mem_write_in,
    input  logic [1:0]       wb_sel_in,
    input  logic [XLEN-1:0]  pc_plus_four_in,
    output logic             alu_zero,
    output logic             valid_out,
    output logic [XLEN-1:0]  alu_result_out,
    output logic [XLEN-1:0]  data_memory_store_out,
    output logic             reg_write_out,
    output logic [4:0]       rd_address_out,
    output logic             data_mem_write_out,
    output logic [1:0]       wb_sel_out,
    output logic [XLEN-1:0]  pc_plus_four_out,
    output logic [CNT_W-1:0] instr_count
);

    logic [XLEN-1:0]  w_alu_result;
    logic             w_alu_zero;

    logic             r_valid;
    logic [XLEN-1:0]  r_alu_result;
    logic [XLEN-1:0]  r_store_data;
    logic             r_reg_write;
    logic [4:0]       r_rd_address;
    logic             r_mem_write;
    logic [1:0]       r_wb_sel;
    logic [XLEN-1:0]  r_pc_plus_four;
    logic [CNT_W-1:0] r_instr_count;

    alu #(.XLEN(XLEN)) u_alu (
        .a      (alu_input1),
        .b      (alu_input2),
        .op     (alu_op_t'(alu_control)),
        .result (w_alu_result),
        .zero   (w_alu_zero)
    );

    // EX/MEM register: reset > flush > stall > load
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            r_valid        <= 1'b0;
            r_alu_result   <= {XLEN{1'b0}};
            r_store_data   <= {XLEN{1'b0}};
            r_reg_write    <= 1'b0;
            r_rd_address   <= 5'd0;
            r_mem_write    <= 1'b0;
            r_wb_sel       <= 2'b00;
            r_pc_plus_four <= {XLEN{1'b0}};
        end else if (stall) begin
            r_valid        <= r_valid;
            r_alu_result   <= r_alu_result;
            r_store_data   <= r_store_data;
            r_reg_write    <= r_reg_write;
            r_rd_address   <= r_rd_address;
            r_mem_write    <= r_mem_write;
            r_wb_sel       <= r_wb_sel;
            r_pc_plus_four <= r_pc_plus_four;
        end else begin
            r_valid        <= valid_in;
            r_alu_result   <= w_alu_result;
            r_store_data   <= data_memory_store_in;
            // x0 is never written, and bubbles never write anything
            r_reg_write    <= reg_write_in & valid_in & (rd_address_in != 5'd0);
            r_rd_address   <= rd_address_in;
            r_mem_write    <= data_mem_write_in & valid_in;
            r_wb_sel       <= wb_sel_in;
            r_pc_plus_four <= pc_plus_four_in;
        end
    end

    // Instruction counter: only valid normal loads advance it (wraps naturally)
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_instr_count <= {CNT_W{1'b0}};
        end else if (!flush && !stall && valid_in) begin
            r_instr_count <= r_instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_instr_count <= r_instr_count;
        end
    end

    assign alu_zero              = w_alu_zero;
    assign valid_out             = r_valid;
    assign alu_result_out        = r_alu_result;
    assign data_memory_store_out = r_store_data;
    assign reg_write_out         = r_reg_write;
    assign rd_address_out        = r_rd_address;
    assign data_mem_write_out    = r_mem_write;
    assign wb_sel_out            = r_wb_sel;
    assign pc_plus_four_out      = r_pc_plus_four;
    assign instr_count           = r_instr_count;

endmodule
